// File: rtl/banco_pkg.sv
// Shared types and widths for the register-bank writeback arbiter.
//   REG_W              register address width (32 registers)
//   DATA_W             register data width
//   entrada_escrita_t  one queued write: destination register + data
//   req_id_t           requester identity (ULA result / memory load)
package banco_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] dado;
    } entrada_escrita_t;

    typedef enum logic {
        REQ_ULA = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

endpackage

// File: rtl/arbitro_escrita_registradores_if.sv
// Bundle of every signal exchanged between the writeback sources/decode stage
// and the register-bank write arbiter.
//   master : upstream side (drives requests and hazard query addresses)
//   slave  : arbiter side (drives ready, hazard flags and the bank write port)
interface arbitro_escrita_registradores_if;
    import banco_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [REG_W-1:0]  req0_reg;
    logic [DATA_W-1:0] req0_dado;
    logic              req1_valid;
    logic              req1_ready;
    logic [REG_W-1:0]  req1_reg;
    logic [DATA_W-1:0] req1_dado;
    logic [REG_W-1:0]  r1;
    logic [REG_W-1:0]  r2;
    logic              pend_r1;
    logic              pend_r2;
    logic              RegWrite;
    logic [REG_W-1:0]  r3;
    logic [DATA_W-1:0] dado_escrita;
    logic              ocupado;

    modport master (
        output req0_valid, req0_reg, req0_dado,
        output req1_valid, req1_reg, req1_dado,
        output r1, r2,
        input  req0_ready, req1_ready,
        input  pend_r1, pend_r2,
        input  RegWrite, r3, dado_escrita, ocupado
    );

    modport slave (
        input  req0_valid, req0_reg, req0_dado,
        input  req1_valid, req1_reg, req1_dado,
        input  r1, r2,
        output req0_ready, req1_ready,
        output pend_r1, pend_r2,
        output RegWrite, r3, dado_escrita, ocupado
    );

endinterface

// File: rtl/fifo_escrita.sv
// DEPTH-entry synchronous FIFO of pending register writes (one per requester).
//   clock, reset : system clock, synchronous active-high reset (empties FIFO)
//   push, din    : enqueue din at posedge (caller guarantees count < DEPTH)
//   pop          : dequeue head at posedge (caller guarantees count > 0)
//   head         : oldest entry (combinational, valid when count > 0)
//   count        : number of stored entries
//   ent_valid    : per-slot occupancy, ent_addr: per-slot destination register;
//                  together they feed the read-after-write hazard compare.
module fifo_escrita
    import banco_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  entrada_escrita_t              din,
    output entrada_escrita_t              head,
    output logic [CNT_W-1:0]              count,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][REG_W-1:0]   ent_addr
);

    entrada_escrita_t mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not cleared on reset: stale slots are invisible because
    // occupancy is derived from count.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A slot is occupied when its distance from the read pointer (mod DEPTH)
    // is below the current count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [PTR_W-1:0] offset;
        assign offset        = PTR_W'(gi) - rd_ptr_q;
        assign ent_valid[gi] = (CNT_W'(offset) < count_q);
        assign ent_addr[gi]  = mem_q[gi].addr;
    end

endmodule

// File: rtl/arbitro_escrita_registradores.sv
// Shares the single write port of the 32x32 register bank between the ULA
// result (requester 0) and the memory load (requester 1). Each requester has
// its own FIFO; a round-robin arbiter issues at most one registered write per
// cycle (RegWrite/r3/dado_escrita), and read-after-write hazards are reported
// for the decode read addresses r1/r2.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : req0_*/req1_* valid/ready requests, r1/r2 hazard queries,
//                  pend_r1/pend_r2, RegWrite/r3/dado_escrita, ocupado
// Optional build macro ZERO_REG_DISCARD_EN: writes to register 0 still consume
// a grant slot but never raise RegWrite, and register 0 is never reported as
// pending. Without it register 0 behaves like any other register.
module arbitro_escrita_registradores
    import banco_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    arbitro_escrita_registradores_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    logic [1:0]                   push;
    logic [1:0]                   pop;
    logic [1:0]                   cand;
    entrada_escrita_t             req_ent   [2];
    entrada_escrita_t             head      [2];
    logic [CNT_W-1:0]             count     [2];
    logic [DEPTH-1:0]             ent_valid [2];
    logic [DEPTH-1:0][REG_W-1:0]  ent_addr  [2];

    req_id_t           rr_last_q, rr_last_d;
    req_id_t           grant_id;
    logic              grant_any;
    logic              grant_writes;
    entrada_escrita_t  granted;
    logic              reg_write_q, reg_write_d;
    logic [REG_W-1:0]  r3_q, r3_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic              pend1, pend2;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign req_ent[0] = {bus.req0_reg, bus.req0_dado};
    assign req_ent[1] = {bus.req1_reg, bus.req1_dado};
    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    // ready looks only at the registered count, so a full FIFO refuses a push
    // even in a cycle where it is being popped.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_ready[gi] = (count[gi] < CNT_W'(DEPTH));
        assign push[gi]      = req_valid[gi] && req_ready[gi];
        assign cand[gi]      = (count[gi] != '0);

        fifo_escrita #(.DEPTH(DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[gi]),
            .pop       (pop[gi]),
            .din       (req_ent[gi]),
            .head      (head[gi]),
            .count     (count[gi]),
            .ent_valid (ent_valid[gi]),
            .ent_addr  (ent_addr[gi])
        );
    end

    // Round robin: on contention the requester that did not win last time wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = REQ_ULA;
        if (cand[0] && cand[1]) begin
            grant_any = 1'b1;
            grant_id  = (rr_last_q == REQ_ULA) ? REQ_MEM : REQ_ULA;
        end else if (cand[0]) begin
            grant_any = 1'b1;
            grant_id  = REQ_ULA;
        end else if (cand[1]) begin
            grant_any = 1'b1;
            grant_id  = REQ_MEM;
        end
    end

    assign granted = (grant_id == REQ_MEM) ? head[1] : head[0];

`ifdef ZERO_REG_DISCARD_EN
    assign grant_writes = (granted.addr != '0);
`else
    assign grant_writes = 1'b1;
`endif

    always_comb begin
        pop         = '0;
        rr_last_d   = rr_last_q;
        reg_write_d = 1'b0;
        r3_d        = r3_q;
        dado_d      = dado_q;
        if (grant_any) begin
            pop[grant_id] = 1'b1;
            rr_last_d     = grant_id;
            if (grant_writes) begin
                reg_write_d = 1'b1;
                r3_d        = granted.addr;
                dado_d      = granted.dado;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q   <= REQ_MEM;
            reg_write_q <= 1'b0;
            r3_q        <= '0;
            dado_q      <= '0;
        end else begin
            rr_last_q   <= rr_last_d;
            reg_write_q <= reg_write_d;
            r3_q        <= r3_d;
            dado_q      <= dado_d;
        end
    end

    // A register is pending while any queued entry targets it or while it is
    // the write currently presented to the bank.
    always_comb begin
        pend1 = reg_write_q && (r3_q == bus.r1);
        pend2 = reg_write_q && (r3_q == bus.r2);
        for (int q = 0; q < 2; q++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (ent_valid[q][e] && (ent_addr[q][e] == bus.r1)) pend1 = 1'b1;
                if (ent_valid[q][e] && (ent_addr[q][e] == bus.r2)) pend2 = 1'b1;
            end
        end
`ifdef ZERO_REG_DISCARD_EN
        if (bus.r1 == '0) pend1 = 1'b0;
        if (bus.r2 == '0) pend2 = 1'b0;
`endif
    end

    assign bus.pend_r1      = pend1;
    assign bus.pend_r2      = pend2;
    assign bus.RegWrite     = reg_write_q;
    assign bus.r3           = r3_q;
    assign bus.dado_escrita = dado_q;
    assign bus.ocupado      = (count[0] != '0) || (count[1] != '0) || reg_write_q;

endmodule
